// File: rtl/udp_pix_rx_if.sv
// UDP receive word stream in, positioned pixel writes and packet status out.
// Pure signal bundle; master is the stack/bench side, slave is the decoder.
// No flow control on pixels; the stack stream is paced only by r_req/r_ack.
interface udp_pix_rx_if;
    logic        r_req;
    logic        r_ack;
    logic        r_enable;
    logic [31:0] r_data;
    logic        pix_valid;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [23:0] pix_rgb;
    logic        pkt_ok;
    logic        pkt_err;
    logic [15:0] pkt_cnt;

    modport master (
        output r_req, r_enable, r_data,
        input  r_ack, pix_valid, pix_x, pix_y, pix_rgb, pkt_ok, pkt_err, pkt_cnt
    );

    modport slave (
        input  r_req, r_enable, r_data,
        output r_ack, pix_valid, pix_x, pix_y, pix_rgb, pkt_ok, pkt_err, pkt_cnt
    );
endinterface

// File: rtl/udp_pix_rx.sv
// UDP packet to pixel-write converter: header check, position word, decimated pixels.
// Latency: pixel word -> pix_valid next cycle; end of stream -> pkt_ok/pkt_err next cycle.
// No backpressure: one pixel per clock, r_ack only offered while idle.
module udp_pix_rx #(
    parameter logic [15:0] DST_PORT = 16'h4000,
    parameter int          MAX_PIX  = 200,
    parameter int          STEP     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    udp_pix_rx_if.slave bus
);
    localparam int          NW     = $clog2(MAX_PIX + 1);
    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [29:0] MAXW   = 30'(MAX_PIX + 1);

    typedef enum logic [2:0] {IDLE, HDR, POS, DATA, DROP} state_t;

    state_t        r_state;
    logic [1:0]    r_wcnt;
    logic          r_bad;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_i;
    logic [11:0]   r_x;
    logic [11:0]   r_y;
    logic          r_pix_vld;
    logic [11:0]   r_pix_x;
    logic [11:0]   r_pix_y;
    logic [23:0]   r_pix_rgb;
    logic          r_ok;
    logic          r_err;
    logic [15:0]   r_cnt;

    logic [29:0]   w_words;
    logic          w_len_ok;

    // Length in words includes the position word, so valid range is 2..MAX_PIX+1.
    assign w_words  = bus.r_data[31:2];
    assign w_len_ok = (bus.r_data[1:0] == 2'b00) && (w_words >= 30'd2) && (w_words <= MAXW);

    assign bus.r_ack     = rst_n && (r_state == IDLE) && bus.r_req;
    assign bus.pix_valid = r_pix_vld;
    assign bus.pix_x     = r_pix_x;
    assign bus.pix_y     = r_pix_y;
    assign bus.pix_rgb   = r_pix_rgb;
    assign bus.pkt_ok    = r_ok;
    assign bus.pkt_err   = r_err;
    assign bus.pkt_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wcnt    <= 2'd0;
            r_bad     <= 1'b0;
            r_n       <= '0;
            r_i       <= '0;
            r_x       <= 12'd0;
            r_y       <= 12'd0;
            r_pix_vld <= 1'b0;
            r_pix_x   <= 12'd0;
            r_pix_y   <= 12'd0;
            r_pix_rgb <= 24'd0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= 16'd0;
        end else begin
            r_pix_vld <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wcnt <= 2'd0;
                    r_bad  <= 1'b0;
                    if (bus.r_req) r_state <= HDR;
                end
                HDR: begin
                    if (bus.r_enable) begin
                        r_wcnt <= r_wcnt + 2'd1;
                        if (r_wcnt == 2'd2 && bus.r_data[15:0] != DST_PORT) r_bad <= 1'b1;
                        if (r_wcnt == 2'd3) begin
                            r_n     <= NW'(w_words - 30'd1);
                            r_state <= (r_bad || !w_len_ok) ? DROP : POS;
                        end
                    end else if (r_wcnt != 2'd0) begin
                        // A gap before the first word is not an end of packet.
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                POS: begin
                    if (bus.r_enable) begin
                        r_y     <= bus.r_data[27:16];
                        r_x     <= bus.r_data[11:0];
                        r_i     <= '0;
                        r_state <= DATA;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DATA: begin
                    if (bus.r_enable) begin
                        if (r_i < r_n) begin
                            r_pix_vld <= 1'b1;
                            r_pix_x   <= r_x;
                            r_pix_y   <= r_y;
                            r_pix_rgb <= bus.r_data[31:8];
                            r_x       <= r_x + STEP12;
                            r_i       <= r_i + NW'(1);
                            if (bus.r_data[7:0] != 8'hFF) r_bad <= 1'b1;
                        end else begin
                            r_bad <= 1'b1;
                        end
                    end else begin
                        if (r_i == r_n && !r_bad) begin
                            r_ok  <= 1'b1;
                            r_cnt <= r_cnt + 16'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    if (!bus.r_enable) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
